// File: rtl/seq_multiplier_32_pkg.sv
// rtl/seq_multiplier_32_pkg.sv - shared encodings and helpers for the sequential RV32M multiplier
package seq_multiplier_32_pkg;

   // op encodings follow funct3[1:0] of the RV32M multiply group
   typedef enum logic [1:0] {
      MUL_OP    = 2'b00,
      MULH_OP   = 2'b01,
      MULHSU_OP = 2'b10,
      MULHU_OP  = 2'b11
   } mul_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      SIGN = 2'b10,
      DONE = 2'b11
   } mul_state_e;

   localparam int MUL_LATENCY = 34;
   localparam int MUL_ITERS   = 32;

   // 0x80000000 maps to itself and is then read as unsigned 2^31
   function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/RippleAdder_32bit.sv
// rtl/RippleAdder_32bit.sv - 32-bit ripple-carry adder shared by the execute-stage multiplier
module RippleAdder_32bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   logic [32:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < 32; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[32];

endmodule

// File: rtl/seq_multiplier_32.sv
// rtl/seq_multiplier_32.sv - iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU
module seq_multiplier_32
   import seq_multiplier_32_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   mul_state_e        state;
   mul_op_e           op_q;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   hi;
   logic [XLEN-1:0]   lo;
   logic              neg;
   logic [4:0]        cnt;

   logic              a_signed;
   logic              b_signed;
   logic [XLEN-1:0]   addend;
   logic [XLEN-1:0]   sum;
   logic              cout;
   logic [2*XLEN-1:0] p_fixed;

   assign a_signed = (op == MULH_OP) || (op == MULHSU_OP);
   assign b_signed = (op == MULH_OP);
   assign addend   = lo[0] ? mag_a : '0;

   // the product is built on magnitudes; the sign is applied once at the end
   assign p_fixed = neg ? (~{hi, lo} + {{(2*XLEN-1){1'b0}}, 1'b1}) : {hi, lo};

   RippleAdder_32bit u_adder (
      .a    (hi),
      .b    (addend),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         op_q   <= MUL_OP;
         mag_a  <= '0;
         hi     <= '0;
         lo     <= '0;
         neg    <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_q  <= mul_op_e'(op);
                  mag_a <= magnitude(a, a_signed);
                  neg   <= (a_signed & a[XLEN-1]) ^ (b_signed & b[XLEN-1]);
                  hi    <= '0;
                  lo    <= magnitude(b, b_signed);
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               // {cout, sum, lo} shifted right by one
               hi  <= {cout, sum[XLEN-1:1]};
               lo  <= {sum[0], lo[XLEN-1:1]};
               cnt <= cnt + 5'd1;
               if (cnt == 5'(MUL_ITERS - 1)) begin
                  state <= SIGN;
               end
            end
            SIGN: begin
               {hi, lo} <= p_fixed;
               result   <= (op_q == MUL_OP) ? p_fixed[XLEN-1:0] : p_fixed[2*XLEN-1:XLEN];
               done     <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier_32.sv
// tb/tb_seq_multiplier_32.sv - self-checking bench for seq_multiplier_32
module tb_seq_multiplier_32;
   import seq_multiplier_32_pkg::*;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op    = 2'b00;
   logic [31:0] a     = '0;
   logic [31:0] b     = '0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks   = 0;
   int failures = 0;

   seq_multiplier_32 #(.XLEN(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] xa, yb, p;
      xa = (o == MULH_OP || o == MULHSU_OP) ? {{32{x[31]}}, x} : {32'h0, x};
      yb = (o == MULH_OP) ? {{32{y[31]}}, y} : {32'h0, y};
      p  = xa * yb;
      return (o == MUL_OP) ? p[31:0] : p[63:32];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // transaction-level model: accepted op, cycles since acceptance, visible result
   logic        m_active = 1'b0;
   int          m_cyc    = 0;
   logic [31:0] m_exp    = '0;
   logic [31:0] m_result = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 1'b0;
         m_cyc    = 0;
         m_result = '0;
      end else if (!m_active) begin
         if (start) begin
            m_active = 1'b1;
            m_cyc    = 0;
            m_exp    = ref_mul(op, a, b);
         end
      end else begin
         m_cyc++;
         if (m_cyc == MUL_LATENCY - 1) m_result = m_exp;
         if (m_cyc == MUL_LATENCY) m_active = 1'b0;
      end
   end

   always @(negedge clk) begin
      check("cmp_busy", busy, m_active);
      check("cmp_done", done, m_active && (m_cyc == MUL_LATENCY - 1));
      check("cmp_result", result, m_result);
   end

   task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] expv, input int poke_at);
      int n;
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         start = (n == poke_at);
         if (start) begin
            op = MULHU_OP; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
         end
      end while (!done && n < 60);
      start = 1'b0;
      check({name, "_result"}, result, expv);
      check({name, "_latency"}, n, MUL_LATENCY);
   endtask

   initial begin
      int n, t1, t2;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_result", result, 32'h0);
      rst_n = 1'b1;

      run_op("mul_3x5",        MUL_OP,    32'd3,         32'd5,         32'd15,        0);
      run_op("mul_m1xm1",      MUL_OP,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
      run_op("mulh_m1xm1",     MULH_OP,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
      run_op("mulhu_max",      MULHU_OP,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
      run_op("mulh_min_min",   MULH_OP,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
      run_op("mulhsu_m1",      MULHSU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op("mulh_min_max",   MULH_OP,   32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 0);
      run_op("mulhsu_min_min", MULHSU_OP, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 0);
      run_op("mulhu_carry",    MULHU_OP,  32'h8000_0000, 32'd2,         32'h0000_0001, 0);
      run_op("mul_zero",       MUL_OP,    32'h1234_5678, 32'd0,         32'h0000_0000, 0);
      run_op("ignored_start",  MUL_OP,    32'd3,         32'd5,         32'd15,        10);

      // start held high: two operations back to back
      @(negedge clk);
      op = MUL_OP; a = 32'd9; b = 32'd11; start = 1'b1;
      n = 0; t1 = -1; t2 = -1;
      while (t2 < 0 && n < 150) begin
         @(negedge clk);
         n++;
         if (done) begin
            if (t1 < 0) t1 = n;
            else t2 = n;
         end
      end
      start = 1'b0;
      check("b2b_first", t1, MUL_LATENCY);
      check("b2b_spacing", t2 - t1, 35);
      check("b2b_result", result, 32'd99);

      // reset in the middle of an operation
      @(negedge clk);
      op = MULHU_OP; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_result", result, 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      run_op("mul_7x6", MUL_OP, 32'd7, 32'd6, 32'd42, 0);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
